// File: rtl/im2col_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | im2col_addr_gen : runtime-configurable Toeplitz (im2col) address gen.   |
// | Revision 1.0                                                            |
// +------------------------------------------------------------------------+
module im2col_addr_gen #(
    parameter int MAX_DIM    = 64,
    parameter int MAX_C      = 64,
    parameter int MAX_KDIM   = 7,
    parameter int MAX_STRIDE = 4,
    parameter int ADDR_W     = 18
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [$clog2(MAX_DIM+1)-1:0]    cfg_in_h,
    input  logic [$clog2(MAX_DIM+1)-1:0]    cfg_in_w,
    input  logic [$clog2(MAX_C+1)-1:0]      cfg_in_c,
    input  logic [$clog2(MAX_KDIM+1)-1:0]   cfg_kh,
    input  logic [$clog2(MAX_KDIM+1)-1:0]   cfg_kw,
    input  logic [$clog2(MAX_STRIDE+1)-1:0] cfg_stride,
    input  logic [$clog2(MAX_KDIM)-1:0]     cfg_pad,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ADDR_W-1:0]               out_addr,
    output logic                            out_pad,
    output logic [15:0]                     out_m,
    output logic [15:0]                     out_k,
    output logic                            out_row_last,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err
);

    localparam int DIM_W = $clog2(MAX_DIM+1);
    localparam int C_W   = $clog2(MAX_C+1);
    localparam int K_W   = $clog2(MAX_KDIM+1);
    localparam int S_W   = $clog2(MAX_STRIDE+1);
    localparam int P_W   = $clog2(MAX_KDIM);
    localparam int SW    = DIM_W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef logic signed [SW-1:0] coord_t;

    // An origin is the last of its axis when the next one would push the kernel past in+pad.
    function automatic logic org_final(input coord_t           org,
                                       input logic [S_W-1:0]   s,
                                       input logic [K_W-1:0]   kd,
                                       input logic [DIM_W-1:0] dim,
                                       input logic [P_W-1:0]   p);
        return (org + coord_t'(s) + coord_t'(kd)) > (coord_t'(dim) + coord_t'(p));
    endfunction

    logic [1:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic             busy_q, done_q, cfg_err_q;

    logic [DIM_W-1:0] in_h_q, in_w_q;
    logic [C_W-1:0]   in_c_q;
    logic [K_W-1:0]   kh_q, kw_q;
    logic [S_W-1:0]   stride_q;
    logic [P_W-1:0]   cfg_pad_q;

    coord_t           oy_q, oy_d, ox_q, ox_d;
    logic [C_W-1:0]   c_q, c_d;
    logic [K_W-1:0]   ky_q, ky_d, kx_q, kx_d;
    logic [15:0]      m_q, m_d, k_q, k_d;

    logic [ADDR_W-1:0] oaddr_q;
    logic              opad_q, orow_last_q, olast_q;

    logic [SW-1:0]    w_span_h, w_span_w;
    logic             w_cfg_ok, w_idle, w_start_ok, w_fire, w_load;

    assign w_span_h = SW'(cfg_in_h) + (SW'(cfg_pad) << 1);
    assign w_span_w = SW'(cfg_in_w) + (SW'(cfg_pad) << 1);

    assign w_cfg_ok = (cfg_in_h != '0) && (cfg_in_w != '0) && (cfg_in_c != '0) &&
                      (cfg_kh != '0) && (cfg_kw != '0) && (cfg_stride != '0) &&
                      (cfg_stride <= S_W'(MAX_STRIDE)) &&
                      (cfg_in_h <= DIM_W'(MAX_DIM)) && (cfg_in_w <= DIM_W'(MAX_DIM)) &&
                      (cfg_in_c <= C_W'(MAX_C)) &&
                      (SW'(cfg_kh) <= w_span_h) && (SW'(cfg_kw) <= w_span_w);

    assign w_idle     = (state_q == S_IDLE);
    assign w_start_ok = w_idle && start && w_cfg_ok;
    assign w_fire     = valid_q && out_ready;
    assign w_load     = w_start_ok || (w_fire && !olast_q);

    // The first element is built in the start cycle, before the config is latched.
    logic [DIM_W-1:0] e_in_h, e_in_w;
    logic [C_W-1:0]   e_in_c;
    logic [K_W-1:0]   e_kh, e_kw;
    logic [S_W-1:0]   e_stride;
    logic [P_W-1:0]   e_pad;

    assign e_in_h   = w_idle ? cfg_in_h   : in_h_q;
    assign e_in_w   = w_idle ? cfg_in_w   : in_w_q;
    assign e_in_c   = w_idle ? cfg_in_c   : in_c_q;
    assign e_kh     = w_idle ? cfg_kh     : kh_q;
    assign e_kw     = w_idle ? cfg_kw     : kw_q;
    assign e_stride = w_idle ? cfg_stride : stride_q;
    assign e_pad    = w_idle ? cfg_pad    : cfg_pad_q;

    logic w_cur_last_kx, w_cur_last_ky, w_cur_last_c, w_cur_last_ox;

    assign w_cur_last_kx = (kx_q == kw_q - K_W'(1));
    assign w_cur_last_ky = (ky_q == kh_q - K_W'(1));
    assign w_cur_last_c  = (c_q == in_c_q - C_W'(1));
    assign w_cur_last_ox = org_final(ox_q, stride_q, kw_q, in_w_q, cfg_pad_q);

    always_comb begin
        oy_d = oy_q;
        ox_d = ox_q;
        c_d  = c_q;
        ky_d = ky_q;
        kx_d = kx_q;
        m_d  = m_q;
        k_d  = k_q;
        if (w_idle) begin
            oy_d = -coord_t'(cfg_pad);
            ox_d = -coord_t'(cfg_pad);
            c_d  = '0;
            ky_d = '0;
            kx_d = '0;
            m_d  = '0;
            k_d  = '0;
        end else if (!w_cur_last_kx) begin
            kx_d = kx_q + K_W'(1);
            k_d  = k_q + 16'd1;
        end else begin
            kx_d = '0;
            if (!w_cur_last_ky) begin
                ky_d = ky_q + K_W'(1);
                k_d  = k_q + 16'd1;
            end else begin
                ky_d = '0;
                if (!w_cur_last_c) begin
                    c_d = c_q + C_W'(1);
                    k_d = k_q + 16'd1;
                end else begin
                    c_d = '0;
                    k_d = '0;
                    m_d = m_q + 16'd1;
                    if (!w_cur_last_ox) begin
                        ox_d = ox_q + coord_t'(stride_q);
                    end else begin
                        ox_d = -coord_t'(cfg_pad_q);
                        oy_d = oy_q + coord_t'(stride_q);
                    end
                end
            end
        end
    end

    coord_t            w_iy, w_ix;
    logic              w_pad, w_row_last, w_last;
    logic [ADDR_W-1:0] w_addr;

    assign w_iy  = oy_d + coord_t'(ky_d);
    assign w_ix  = ox_d + coord_t'(kx_d);
    assign w_pad = (w_iy < 0) || (w_iy >= coord_t'(e_in_h)) ||
                   (w_ix < 0) || (w_ix >= coord_t'(e_in_w));

    // Inside the image iy/ix are non-negative and below MAX_DIM, so the low bits suffice.
    assign w_addr = w_pad ? '0 :
                    (ADDR_W'(c_d) * ADDR_W'(e_in_h) + ADDR_W'(w_iy[DIM_W-1:0])) * ADDR_W'(e_in_w)
                    + ADDR_W'(w_ix[DIM_W-1:0]);

    assign w_row_last = (kx_d == e_kw - K_W'(1)) && (ky_d == e_kh - K_W'(1)) &&
                        (c_d == e_in_c - C_W'(1));
    assign w_last     = w_row_last &&
                        org_final(ox_d, e_stride, e_kw, e_in_w, e_pad) &&
                        org_final(oy_d, e_stride, e_kh, e_in_h, e_pad);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    state_d = S_RUN;
                    valid_d = 1'b1;
                end
            end
            S_RUN: begin
                if (w_fire && olast_q) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            in_h_q    <= '0;
            in_w_q    <= '0;
            in_c_q    <= '0;
            kh_q      <= '0;
            kw_q      <= '0;
            stride_q  <= '0;
            cfg_pad_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            cfg_err_q <= w_idle && start && !w_cfg_ok;
            if (w_start_ok) begin
                in_h_q    <= cfg_in_h;
                in_w_q    <= cfg_in_w;
                in_c_q    <= cfg_in_c;
                kh_q      <= cfg_kh;
                kw_q      <= cfg_kw;
                stride_q  <= cfg_stride;
                cfg_pad_q <= cfg_pad;
            end
        end
    end

    // Counters always describe the element currently held in the output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oy_q        <= '0;
            ox_q        <= '0;
            c_q         <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            m_q         <= '0;
            k_q         <= '0;
            oaddr_q     <= '0;
            opad_q      <= 1'b0;
            orow_last_q <= 1'b0;
            olast_q     <= 1'b0;
        end else if (w_load) begin
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            c_q         <= c_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            m_q         <= m_d;
            k_q         <= k_d;
            oaddr_q     <= w_addr;
            opad_q      <= w_pad;
            orow_last_q <= w_row_last;
            olast_q     <= w_last;
        end
    end

    assign out_valid    = valid_q;
    assign out_addr     = oaddr_q;
    assign out_pad      = opad_q;
    assign out_m        = m_q;
    assign out_k        = k_q;
    assign out_row_last = orow_last_q;
    assign out_last     = olast_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

endmodule
`default_nettype wire
